// File: rtl/draw_pkg.sv
// Shared types and constants for the draw sequencer.
//   draw_op_t    : command opcode carried through the FIFO
//   draw_cmd_t   : one FIFO entry {op, hand, card}
//   RANK_BACK    : rank code that prints the face-down card back
//   HAND_*       : hand select encoding for DEAL
//   CARD_W/H     : card sprite size in pixels
package draw_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR  = 2'd0,
    OP_DEAL   = 2'd1,
    OP_REVEAL = 2'd2,
    OP_NOP    = 2'd3
  } draw_op_t;

  localparam logic [3:0] RANK_BACK = 4'd14;

  localparam logic HAND_DEALER = 1'b0;
  localparam logic HAND_PLAYER = 1'b1;

  localparam int unsigned CARD_W = 11;
  localparam int unsigned CARD_H = 16;

  typedef struct packed {
    draw_op_t   op;
    logic       hand;
    logic [5:0] card;
  } draw_cmd_t;

endpackage

// File: rtl/draw_fifo.sv
// Synchronous FIFO, first-word-fall-through.
//   clk, rst              : clock, asynchronous active-high reset
//   push_valid/push_ready : write side; push = push_valid && push_ready
//   push_data             : entry written on push
//   empty                 : no entries stored
//   pop                   : retire the head entry (ignored when empty)
//   pop_data              : current head entry
module draw_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             empty,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : gen_bad_depth
    $error("draw_fifo: DEPTH must be a power of 2 and >= 2");
  end

  // Extra MSB distinguishes full from empty when the index bits match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, do_push, do_pop;

  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign push_ready = !full;
  assign do_push    = push_valid && !full;
  assign do_pop     = pop && !empty;
  assign pop_data   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/draw_sequencer.sv
// Draw command sequencer: queues draw commands and issues one print request at a time.
//   clk, rst                 : clock, asynchronous active-high reset
//   cmd_valid/ready          : command push handshake
//   cmd_op/hand/card         : command fields (see draw_pkg)
//   write/init/card/orig     : print request; orig = {x[7:0], y[6:0]}
//   waitrequest              : print engine stall; accept = write && !waitrequest
//   busy                     : FIFO non-empty or request outstanding
//   dealer_count/player_count: cards drawn in each row
//   overflow_err             : sticky, a command was dropped; cleared by CLEAR
//   issued_count             : accepted requests, saturating (only with
//                              DRAW_SEQUENCER_STATS_EN defined)
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_SLOTS = 11,
  parameter int unsigned X0        = 4,
  parameter int unsigned PITCH     = 13,
  parameter int unsigned DEALER_Y  = 8,
  parameter int unsigned PLAYER_Y  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic        cmd_hand,
  input  logic [5:0]  cmd_card,
  output logic        write,
  output logic        init,
  output logic [5:0]  card,
  output logic [14:0] orig,
  input  logic        waitrequest,
  output logic        busy,
  output logic [3:0]  dealer_count,
  output logic [3:0]  player_count,
  output logic        overflow_err
`ifdef DRAW_SEQUENCER_STATS_EN
  ,
  output logic [15:0] issued_count
`endif
);

  if (X0 + (MAX_SLOTS - 1) * PITCH + CARD_W - 1 > 159) begin : gen_bad_geometry
    $error("draw_sequencer: last card slot runs past x=159");
  end
  if (MAX_SLOTS > 15) begin : gen_bad_slots
    $error("draw_sequencer: MAX_SLOTS must fit the 4-bit hand counters");
  end

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e      state_q, state_d;
  logic        init_q, init_d;
  logic [5:0]  card_q, card_d;
  logic [14:0] orig_q, orig_d;
  logic [3:0]  dealer_cnt_q, dealer_cnt_d;
  logic [3:0]  player_cnt_q, player_cnt_d;
  logic        ovf_q, ovf_d;

  draw_cmd_t   cmd_in, head;
  logic        fifo_empty, pop;
  logic [3:0]  head_cnt;
  logic [6:0]  row_y;
  logic [7:0]  slot_x;

  assign cmd_in = {cmd_op, cmd_hand, cmd_card};

  draw_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(draw_cmd_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (cmd_valid),
    .push_ready (cmd_ready),
    .push_data  (cmd_in),
    .empty      (fifo_empty),
    .pop        (pop),
    .pop_data   (head)
  );

  assign head_cnt = (head.hand == HAND_PLAYER) ? player_cnt_q : dealer_cnt_q;
  assign row_y    = (head.hand == HAND_PLAYER) ? 7'(PLAYER_Y) : 7'(DEALER_Y);
  assign slot_x   = 8'(X0) + 8'(head_cnt) * 8'(PITCH);

  // The head stays in the FIFO while its request is outstanding; it is popped
  // on acceptance so its op/hand are still available to apply the effect.
  always_comb begin
    state_d      = state_q;
    init_d       = init_q;
    card_d       = card_q;
    orig_d       = orig_q;
    dealer_cnt_d = dealer_cnt_q;
    player_cnt_d = player_cnt_q;
    ovf_d        = ovf_q;
    pop          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          unique case (head.op)
            OP_CLEAR: begin
              init_d  = 1'b1;
              card_d  = '0;
              orig_d  = '0;
              state_d = StIssue;
            end
            OP_DEAL: begin
              if (head_cnt == 4'(MAX_SLOTS)) begin
                pop   = 1'b1;
                ovf_d = 1'b1;
              end else begin
                init_d  = 1'b0;
                card_d  = head.card;
                orig_d  = {slot_x, row_y};
                state_d = StIssue;
              end
            end
            OP_REVEAL: begin
              if (dealer_cnt_q == '0) begin
                pop   = 1'b1;
                ovf_d = 1'b1;
              end else begin
                init_d  = 1'b0;
                card_d  = head.card;
                orig_d  = {8'(X0), 7'(DEALER_Y)};
                state_d = StIssue;
              end
            end
            default: pop = 1'b1;  // OP_NOP
          endcase
        end
      end
      StIssue: begin
        if (!waitrequest) begin
          pop     = 1'b1;
          state_d = StIdle;
          if (head.op == OP_CLEAR) begin
            dealer_cnt_d = '0;
            player_cnt_d = '0;
            ovf_d        = 1'b0;
          end else if (head.op == OP_DEAL) begin
            if (head.hand == HAND_PLAYER) player_cnt_d = player_cnt_q + 4'd1;
            else                          dealer_cnt_d = dealer_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      init_q       <= 1'b0;
      card_q       <= '0;
      orig_q       <= '0;
      dealer_cnt_q <= '0;
      player_cnt_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_q       <= init_d;
      card_q       <= card_d;
      orig_q       <= orig_d;
      dealer_cnt_q <= dealer_cnt_d;
      player_cnt_q <= player_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  // write comes straight from state so an asynchronous reset drops it at once.
  assign write        = (state_q == StIssue);
  assign init         = init_q;
  assign card         = card_q;
  assign orig         = orig_q;
  assign busy         = !fifo_empty || write;
  assign dealer_count = dealer_cnt_q;
  assign player_count = player_cnt_q;
  assign overflow_err = ovf_q;

`ifdef DRAW_SEQUENCER_STATS_EN
  logic [15:0] issued_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
    end else if (write && !waitrequest && issued_q != 16'hFFFF) begin
      issued_q <= issued_q + 16'd1;
    end
  end

  assign issued_count = issued_q;
`endif

endmodule

// File: tb/tb_draw_sequencer.sv
module tb_draw_sequencer;
  import draw_pkg::*;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic        cmd_hand;
  logic [5:0]  cmd_card;
  logic        write, init;
  logic [5:0]  card;
  logic [14:0] orig;
  logic        waitrequest, busy;
  logic [3:0]  dealer_count, player_count;
  logic        overflow_err;
`ifdef DRAW_SEQUENCER_STATS_EN
  logic [15:0] issued_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  draw_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_hand     (cmd_hand),
    .cmd_card     (cmd_card),
    .write        (write),
    .init         (init),
    .card         (card),
    .orig         (orig),
    .waitrequest  (waitrequest),
    .busy         (busy),
    .dealer_count (dealer_count),
    .player_count (player_count),
    .overflow_err (overflow_err)
`ifdef DRAW_SEQUENCER_STATS_EN
    ,
    .issued_count (issued_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] mk_orig(input int x, input int y);
    return {8'(x), 7'(y)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic hand, input logic [5:0] c);
    for (int k = 0; k < 20 && !cmd_ready; k++) tick();
    check("push_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_hand  = hand;
    cmd_card  = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_write(input int max, output logic seen);
    seen = 1'b0;
    for (int k = 0; k < max; k++) begin
      if (write) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Push one command with waitrequest low and capture the resulting request, if any.
  task automatic run_cmd(input logic [1:0] op, input logic hand, input logic [5:0] c,
                         output logic seen, output logic [5:0] got_card,
                         output logic [14:0] got_orig, output logic got_init);
    push(op, hand, c);
    wait_write(8, seen);
    got_card = card;
    got_orig = orig;
    got_init = init;
    if (seen) tick();
  endtask

  logic        seen, gi;
  logic [5:0]  gc;
  logic [14:0] go;
  logic        any_write;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'd0;
    cmd_hand = 1'b0;
    cmd_card = 6'd0;
    waitrequest = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_outputs", {write, init, card, orig, busy, overflow_err},
          32'd0);
    check("rst_counts", {dealer_count, player_count}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // CLEAR stalled by waitrequest for 5 cycles
    waitrequest = 1'b1;
    push(2'd0, 1'b0, 6'd0);
    check("clear_latency_pre", {31'd0, write}, 32'd0);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("clear_held", {write, init, card, orig}, {1'b1, 1'b1, 6'd0, 15'd0});
      tick();
    end
    waitrequest = 1'b0;
    tick();
    check("clear_done", {write, busy}, 32'd0);
    check("clear_counts", {dealer_count, player_count, 3'd0, overflow_err}, 32'd0);

    // Two player deals
    run_cmd(2'd1, 1'b1, 6'h09, seen, gc, go, gi);
    check("deal1_seen", {31'd0, seen}, 32'd1);
    check("deal1_req", {gi, gc, go}, {1'b0, 6'h09, mk_orig(4, 64)});
    run_cmd(2'd1, 1'b1, 6'h0E, seen, gc, go, gi);
    check("deal2_req", {seen, gi, gc, go}, {1'b1, 1'b0, 6'h0E, mk_orig(17, 64)});
    check("deal2_count", {28'd0, player_count}, 32'd2);

    // Fill dealer row, then overflow
    for (int i = 0; i < 11; i++) begin
      run_cmd(2'd1, 1'b0, 6'(i + 1), seen, gc, go, gi);
      if (i == 10) check("deal11_req", {seen, gc, go}, {1'b1, 6'd11, mk_orig(134, 8)});
    end
    check("dealer_full", {28'd0, dealer_count}, 32'd11);
    run_cmd(2'd1, 1'b0, 6'h20, seen, gc, go, gi);
    check("deal12_nowrite", {31'd0, seen}, 32'd0);
    check("deal12_ovf", {27'd0, overflow_err, dealer_count}, {27'd0, 1'b1, 4'd11});
    run_cmd(2'd0, 1'b0, 6'd0, seen, gc, go, gi);
    check("clear2_req", {seen, gi}, 32'd3);
    check("clear2_state", {overflow_err, dealer_count, player_count}, 32'd0);

    // REVEAL with empty dealer row, then valid REVEAL
    run_cmd(2'd2, 1'b0, 6'h05, seen, gc, go, gi);
    check("reveal0_drop", {seen, overflow_err}, 32'd1);
    run_cmd(2'd1, 1'b0, 6'h10, seen, gc, go, gi);
    check("dealer_deal", {seen, gc, go}, {1'b1, 6'h10, mk_orig(4, 8)});
    run_cmd(2'd2, 1'b1, 6'h05, seen, gc, go, gi);
    check("reveal_req", {seen, gi, gc, go}, {1'b1, 1'b0, 6'h05, mk_orig(4, 8)});
    check("reveal_count", {27'd0, overflow_err, dealer_count}, {27'd0, 1'b1, 4'd1});

    // NOP has no visible effect
    run_cmd(2'd3, 1'b1, 6'h3F, seen, gc, go, gi);
    check("nop", {seen, busy, player_count, dealer_count}, {1'b0, 1'b0, 4'd0, 4'd1});

    // FIFO full with engine stalled; ordering preserved
    waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_hand  = 1'b1;
      cmd_card  = 6'(i + 1);
      tick();
    end
    check("full_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_card = 6'd5;
    tick();
    check("full_hold", {cmd_ready, write, card, orig}, {1'b0, 1'b1, 6'd1, mk_orig(4, 64)});
    waitrequest = 1'b0;
    tick();
    check("first_accept", {write, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_write(8, seen);
      check("order_req", {seen, card, orig}, {1'b1, 6'(i + 2), mk_orig(17 + 13 * i, 64)});
      tick();
    end
    check("order_count", {28'd0, player_count}, 32'd5);

    // Reset during ISSUE
    waitrequest = 1'b1;
    push(2'd1, 1'b0, 6'h07);
    wait_write(8, seen);
    check("pre_rst_write", {31'd0, seen}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", {write, busy, cmd_ready}, 32'd1);
    check("rst_mid_counts", {overflow_err, dealer_count, player_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    waitrequest = 1'b0;
    any_write = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (write) any_write = 1'b1;
    end
    check("post_rst_quiet", {any_write, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
